// File: rtl/spike_synapse_pkg.sv
// spike_pkg: shared widths, status encoding and saturating 8-bit helpers for spike_synapse.
package spike_pkg;
  localparam int CUR_W = 8;
  localparam logic [CUR_W-1:0] CUR_MAX = 8'd255;
  typedef enum logic [1:0] {IDLE, ACTIVE, REFR} status_t;
  function automatic logic [CUR_W-1:0] sat_add8(input logic [CUR_W-1:0] a, input logic [CUR_W-1:0] b);
    logic [CUR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CUR_W] ? CUR_MAX : s[CUR_W-1:0];
  endfunction
  function automatic logic [CUR_W-1:0] sat_sub8(input logic [CUR_W-1:0] a, input logic [CUR_W-1:0] b);
    return a > b ? a - b : '0;
  endfunction
endpackage

// File: rtl/spike_synapse_if.sv
// spike_synapse_if: spike/weight inputs and current/status outputs; inhib exists only with SYN_INHIB_EN.
interface spike_synapse_if;
  import spike_pkg::*;
  logic             spike_in;
  logic [CUR_W-1:0] weight_in;
  logic             weight_we;
  logic [CUR_W-1:0] syn_current;
  logic             refractory;
  logic [CUR_W-1:0] event_cnt;
`ifdef SYN_INHIB_EN
  logic             inhib;
  modport master(output spike_in, weight_in, weight_we, inhib, input syn_current, refractory, event_cnt);
  modport slave(input spike_in, weight_in, weight_we, inhib, output syn_current, refractory, event_cnt);
`else
  modport master(output spike_in, weight_in, weight_we, input syn_current, refractory, event_cnt);
  modport slave(input spike_in, weight_in, weight_we, output syn_current, refractory, event_cnt);
`endif
endinterface

// File: rtl/spike_synapse_decay.sv
// syn_decay: free-running decay prescaler and exponential decay amount (min 1 while current is nonzero).
module syn_decay
  import spike_pkg::*;
#(
  parameter int TAU_SHIFT = 3,
  parameter int DECAY_DIV = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CUR_W-1:0] cur,
  output logic             tick,
  output logic [CUR_W-1:0] d
);
  localparam int PW = DECAY_DIV > 0 ? DECAY_DIV : 1;
  localparam logic [PW-1:0] PMAX = PW'((1 << DECAY_DIV) - 1);
  logic [PW-1:0]    prescaler;
  logic [CUR_W-1:0] shifted;
  assign tick = prescaler == PMAX;
  assign shifted = cur >> TAU_SHIFT;
  assign d = (tick && cur != '0) ? (shifted == '0 ? CUR_W'(1) : shifted) : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prescaler <= '0;
    else prescaler <= tick ? '0 : prescaler + 1'b1;
endmodule

// File: rtl/spike_synapse.sv
// spike_synapse: rising-edge spike to saturating decaying synaptic current with refractory window.
// Define SYN_INHIB_EN to add the inhib input (inhibitory events subtract the weight).
module spike_synapse
  import spike_pkg::*;
#(
  parameter logic [CUR_W-1:0] WEIGHT_INIT = 8'd40,
  parameter int TAU_SHIFT = 3,
  parameter int DECAY_DIV = 0,
  parameter int REFRACT = 4
) (
  input logic clk,
  input logic rst_n,
  spike_synapse_if.slave bus
);
  logic             spike_d, tick, rise, accept, inhibit;
  logic [CUR_W-1:0] cur, d, cur_dec, next_cur, refr_cnt, next_refr, weight, event_cnt;
  status_t          state;
  syn_decay #(.TAU_SHIFT(TAU_SHIFT), .DECAY_DIV(DECAY_DIV)) u_decay (
    .clk(clk), .rst_n(rst_n), .cur(cur), .tick(tick), .d(d)
  );
`ifdef SYN_INHIB_EN
  assign inhibit = bus.inhib;
`else
  assign inhibit = 1'b0;
`endif
  // state is REFR exactly when refr_cnt is nonzero, so it gates acceptance
  assign rise = bus.spike_in & ~spike_d;
  assign accept = rise & (state != REFR);
  assign cur_dec = cur - d;
  assign next_cur = !accept ? cur_dec : inhibit ? sat_sub8(cur_dec, weight) : sat_add8(cur_dec, weight);
  assign next_refr = accept ? CUR_W'(REFRACT) : refr_cnt != '0 ? refr_cnt - 1'b1 : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      spike_d   <= 1'b0;
      cur       <= '0;
      refr_cnt  <= '0;
      weight    <= WEIGHT_INIT;
      event_cnt <= '0;
      state     <= IDLE;
    end else begin
      spike_d   <= bus.spike_in;
      cur       <= next_cur;
      refr_cnt  <= next_refr;
      weight    <= bus.weight_we ? bus.weight_in : weight;
      event_cnt <= (accept && event_cnt != CUR_MAX) ? event_cnt + 1'b1 : event_cnt;
      state     <= accept ? REFR :
                   state == REFR ? (next_refr != '0 ? REFR : next_cur != '0 ? ACTIVE : IDLE) :
                   (state == ACTIVE && tick && next_cur == '0) ? IDLE : state;
    end
  assign bus.syn_current = cur;
  assign bus.refractory = refr_cnt != '0;
  assign bus.event_cnt = event_cnt;
endmodule

// File: tb/tb_spike_synapse.sv
// tb_spike_synapse: scoreboarded random/directed bench for two spike_synapse instances (DECAY_DIV 0 and 2).
module tb_spike_synapse;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  spike_synapse_if b0 ();
  spike_synapse_if b1 ();
  spike_synapse #(.DECAY_DIV(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  spike_synapse #(.DECAY_DIV(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  always #5 clk = ~clk;

  typedef struct {
    int c0, r0, e0, c1, r1, e1;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int passed = 0, total = 0;
  int m_cur[2], m_refr[2], m_ev[2];
  int m_w, m_n;
  bit m_prev;

  function automatic int div(input int k);
    return k == 0 ? 1 : 4;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cur[k] = 0;
      m_refr[k] = 0;
      m_ev[k] = 0;
    end
    m_w = 40;
    m_n = 0;
    m_prev = 0;
  endtask

  task automatic set_inputs(input bit s, input bit we, input int w, input bit inh);
    b0.spike_in = s;
    b1.spike_in = s;
    b0.weight_we = we;
    b1.weight_we = we;
    b0.weight_in = 8'(w);
    b1.weight_in = 8'(w);
`ifdef SYN_INHIB_EN
    b0.inhib = inh;
    b1.inhib = inh;
`else
    if (inh) begin end
`endif
  endtask

  // Apply one cycle of stimulus at a falling edge and queue the expected outputs.
  task automatic drive(input bit s, input bit we = 0, input int w = 0, input bit inh = 0);
    exp_t e;
    bit ie;
    ie = 0;
`ifdef SYN_INHIB_EN
    ie = inh;
`endif
    set_inputs(s, we, w, inh);
    for (int k = 0; k < 2; k++) begin
      bit tk, acc;
      int dec;
      tk = (m_n % div(k)) == div(k) - 1;
      acc = s && !m_prev && m_refr[k] == 0;
      dec = (tk && m_cur[k] > 0) ? ((m_cur[k] / 8 > 0) ? m_cur[k] / 8 : 1) : 0;
      m_cur[k] -= dec;
      if (acc) begin
        if (ie) m_cur[k] = m_cur[k] > m_w ? m_cur[k] - m_w : 0;
        else m_cur[k] = m_cur[k] + m_w > 255 ? 255 : m_cur[k] + m_w;
        if (m_ev[k] < 255) m_ev[k]++;
        m_refr[k] = 4;
      end else if (m_refr[k] > 0) m_refr[k]--;
    end
    if (we) m_w = w;
    m_prev = s;
    m_n++;
    e.c0 = m_cur[0]; e.r0 = m_refr[0] != 0; e.e0 = m_ev[0];
    e.c1 = m_cur[1]; e.r1 = m_refr[1] != 0; e.e1 = m_ev[1];
    sb.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("cur_div1", int'(b0.syn_current), mon_e.c0);
      chk("refr_div1", int'(b0.refractory), mon_e.r0);
      chk("evt_div1", int'(b0.event_cnt), mon_e.e0);
      chk("cur_div4", int'(b1.syn_current), mon_e.c1);
      chk("refr_div4", int'(b1.refractory), mon_e.r1);
      chk("evt_div4", int'(b1.event_cnt), mon_e.e1);
    end
  end

  initial begin
    set_inputs(0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_cur", int'(b0.syn_current), 0);
    chk("reset_refr", int'(b0.refractory), 0);
    chk("reset_evt", int'(b0.event_cnt), 0);
    // single spike held 5 cycles
    drive(1);
    chk("single_c1", int'(b0.syn_current), 40);
    chk("single_refr1", int'(b0.refractory), 1);
    chk("div4_c1", int'(b1.syn_current), 40);
    drive(1);
    chk("single_c2", int'(b0.syn_current), 35);
    drive(1);
    chk("single_c3", int'(b0.syn_current), 31);
    chk("div4_c3", int'(b1.syn_current), 40);
    drive(1);
    chk("single_c4", int'(b0.syn_current), 28);
    chk("single_refr4", int'(b0.refractory), 1);
    chk("div4_c4", int'(b1.syn_current), 35);
    drive(1);
    chk("single_c5", int'(b0.syn_current), 25);
    chk("single_refr5", int'(b0.refractory), 0);
    chk("single_evt", int'(b0.event_cnt), 1);
    repeat (120) drive(0);
    // saturation with refractory drops at t2, t4
    drive(0, 1, 200);
    for (int i = 0; i < 7; i++) begin
      drive(i % 2 == 0);
      if (i == 0) chk("sat_t0", int'(b0.syn_current), 200);
      if (i == 5) chk("sat_t5", int'(b0.syn_current), 105);
    end
    chk("sat_t6", int'(b0.syn_current), 255);
    chk("sat_evt", int'(b0.event_cnt), 3);
    repeat (120) drive(0);
    // weight write colliding with an accept uses the old weight
    drive(0, 1, 40);
    repeat (2) drive(0);
    drive(1, 1, 90);
    chk("collide_old_w", int'(b0.syn_current), 40);
    repeat (60) drive(0);
    drive(1);
    chk("collide_new_w", int'(b0.syn_current), 90);
    chk("collide_evt", int'(b0.event_cnt), 5);
    // asynchronous reset asserted mid-cycle
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_cur", int'(b0.syn_current), 0);
    chk("async_evt", int'(b0.event_cnt), 0);
    chk("async_cur_div4", int'(b1.syn_current), 0);
    @(negedge clk);
    set_inputs(0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive(1);
    chk("post_reset_w", int'(b0.syn_current), 40);
    repeat (1500) begin
      bit s;
      s = ($urandom_range(0, 2) == 0) ? ~m_prev : m_prev;
      drive(s, $urandom_range(0, 19) == 0, $urandom_range(0, 255), 1'($urandom));
    end
    @(posedge clk);
    #2;
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
